mem_bus_ctrl: RTL
=================

Name: mem_bus_ctrl

Overview:
Memory-side controller directly downstream of the CPU core's memory port. It accepts one load, store or instruction-fetch request at a time and decodes the address to on-chip RAM, the MMIO port, or unmapped space. Loads are right-aligned and sign/zero-extended per RISC-V funct3. Stores are converted to byte enables. Each request returns a single-cycle done pulse, with an error flag where applicable.

Parameters:
RAM_WORDS, 1024, on-chip RAM depth in 32-bit words; power of two; RAM decodes from byte address 0.
IO_BASE, 32'h8000_0000, MMIO region base; a request is MMIO when addr[31:28] == IO_BASE[31:28].
TIMEOUT_CYCLES, 255, MMIO ack timeout; used only with the optional feature.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cpu_req  in  1  request valid; requester holds req and payload stable until cpu_done
cpu_we  in  1  1 = store, 0 = load/fetch
cpu_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; stores use [1:0] only
cpu_addr  in  32  byte address
cpu_wdata  in  32  store data, right-aligned
cpu_rdata  out  32  formatted load data, valid while cpu_done is high
cpu_done  out  1  one-cycle completion pulse
cpu_err  out  1  qualifies cpu_done: misaligned, unmapped, illegal funct3, or timeout
io_req  out  1  MMIO request, held until io_ack
io_we  out  1  MMIO write
io_addr  out  32  MMIO word address (addr[1:0] = 0)
io_wdata  out  32  lane-shifted store data
io_be  out  4  byte enables
io_rdata  in  32  MMIO read word
io_ack  in  1  MMIO completion; io_rdata valid in the same cycle

Behaviour:
- Reset: state IDLE; cpu_done, cpu_err, io_req, io_we are 0; cpu_rdata, io_addr, io_wdata are 0; io_be is 0. RAM contents are not reset.
- States: IDLE, RAM_RD, IO_WAIT, RESP.
- IDLE: cpu_req is sampled only in this state.
  - Illegal funct3 (011, 11x), halfword with addr[0]=1, or word with addr[1:0]!=0: go to RESP with err=1. No access occurs.
  - addr < RAM_WORDS*4, store: write RAM at this edge using byte enables, go to RESP.
  - addr < RAM_WORDS*4, load: issue synchronous RAM read, go to RAM_RD.
  - MMIO address: register io_* outputs, assert io_req, go to IO_WAIT.
  - Otherwise (unmapped): go to RESP with err=1.
- Byte enables: B gives 4'b0001 << addr[1:0]; H gives 4'b0011 << {addr[1],1'b0}; W gives 4'b1111. wdata is replicated or shifted into the matching lanes.
- RAM_RD: format the RAM output word into cpu_rdata, go to RESP.
- Load formatting: select the lane by addr[1:0]. funct3[2]=0 sign-extends; funct3[2]=1 zero-extends.
- IO_WAIT: hold io_req and payload. On io_ack: drop io_req, format io_rdata (loads), go to RESP.
- RESP: cpu_done=1 for exactly one cycle, then IDLE. cpu_err and cpu_rdata are meaningful only in this cycle. On error, cpu_rdata=0.
- Latency from the edge that samples req to the done cycle: RAM store 1 cycle; RAM load 2 cycles; MMIO is ack cycle + 1; error 1 cycle.
- Back-to-back: the next request is accepted in the IDLE cycle after RESP, giving a minimum 2-cycle spacing.
- RAM address wrap is impossible; anything outside the RAM range is decoded as unmapped.
- Reset mid-operation returns to IDLE immediately with io_req=0 and no cpu_done. An in-flight MMIO transaction is abandoned; the peripheral must tolerate a dropped io_req.
- An io_ack seen outside IO_WAIT is ignored.

Optional Feature:
MEM_BUS_IO_TIMEOUT_EN
- Defined: IO_WAIT counts cycles from io_req assertion. If TIMEOUT_CYCLES elapse with no ack, drop io_req and go to RESP with err=1, cpu_rdata=0. If ack and expiry occur in the same cycle, ack wins.
- Undefined: no counter; IO_WAIT waits indefinitely. The TIMEOUT_CYCLES parameter is unused.

Decomposition:
- Shared package mem_bus_pkg holds:
  - funct3 size localparams (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU)
  - state enum
  - region enum (REG_RAM, REG_IO, REG_NONE)
  - IO_TIMEOUT width constant
- One sub-module, mem_bus_ram: RAM_WORDS x 32 inferred BRAM with 4-bit byte-enable write and 1-cycle registered read. The controller owns all formatting.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 -> store done 1 cycle after req with err=0; load done 2 cycles after req, rdata=0xDEADBEEF.
- SB 0x80 @0x11, then LB @0x11 and LBU @0x11 -> rdata=0xFFFFFF80, then 0x00000080; the word @0x10 reads 0xDEAD80EF.
- LH @0x13 and LW @0x12 -> each returns done with err=1, rdata=0, and RAM is unchanged.
- LW @0x8000_0004 with io_ack after 3 cycles and io_rdata=0x12345678 -> io_req held 3 cycles, io_be=4'hF, done the cycle after ack, rdata=0x12345678. Also SH 0xABCD @0x8000_0002 -> io_be=4'b1100, io_wdata[31:16]=0xABCD.
- LW @0x4000_0000 (unmapped) -> done with err=1 and no io_req. With MEM_BUS_IO_TIMEOUT_EN and TIMEOUT_CYCLES=8, LW @0x8000_0000 with no ack -> err=1 done after 8 cycles.
- Assert rst during IO_WAIT -> next cycle io_req=0 and no cpu_done; a subsequent RAM LW completes normally.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types, size codes and load/store lane helpers for mem_bus_ctrl
package mem_bus_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam int IO_TIMEOUT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAM_RD,
    ST_IO_WAIT,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_IO,
    REG_NONE
  } region_e;

  // Right-align the addressed lane, then sign- or zero-extend by funct3[2].
  function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                           input logic [1:0]  off,
                                           input logic [2:0]  f3);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3[1:0])
      2'b00:   fmt_load = f3[2] ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   fmt_load = f3[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: fmt_load = sh;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   store_be = 4'b0001 << off;
      2'b01:   store_be = 4'b0011 << {off[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Replicating the source into every lane lets the byte enables pick the target lane.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wdata);
    case (f3[1:0])
      2'b00:   store_lanes = {4{wdata[7:0]}};
      2'b01:   store_lanes = {2{wdata[15:0]}};
      default: store_lanes = wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_ram.sv
// rtl/mem_bus_ram.sv - WORDS x 32 inferred block RAM, byte-enable write, one-cycle registered read
module mem_bus_ram #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - CPU memory-port controller: RAM / MMIO / unmapped decode, one request at a time
// Optional MMIO ack timeout is built when MEM_BUS_IO_TIMEOUT_EN is defined.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int          RAM_WORDS      = 1024,
  parameter logic [31:0] IO_BASE        = 32'h8000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_funct3,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic        io_req,
  output logic        io_we,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  output logic [3:0]  io_be,
  input  logic [31:0] io_rdata,
  input  logic        io_ack
);

  localparam int RAM_AW = $clog2(RAM_WORDS);

  state_e      state_q, state_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        io_req_q, io_req_d;
  logic        io_we_q, io_we_d;
  logic [31:0] io_addr_q, io_addr_d;
  logic [31:0] io_wdata_q, io_wdata_d;
  logic [3:0]  io_be_q, io_be_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;

`ifdef MEM_BUS_IO_TIMEOUT_EN
  localparam logic [IO_TIMEOUT_W-1:0] TMO_LAST = IO_TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  logic [IO_TIMEOUT_W-1:0] tmr_q, tmr_d;
`endif

  region_e     region;
  logic        f3_legal;
  logic        misaligned;
  logic [3:0]  req_be;
  logic [31:0] req_lanes;
  logic        ram_we;
  logic [31:0] ram_rdata;

  always_comb begin
    if (cpu_addr[31:RAM_AW+2] == '0)               region = REG_RAM;
    else if (cpu_addr[31:28] == IO_BASE[31:28])    region = REG_IO;
    else                                           region = REG_NONE;
  end

  assign f3_legal   = (cpu_funct3 == SZ_B)  || (cpu_funct3 == SZ_H)  || (cpu_funct3 == SZ_W) ||
                      (cpu_funct3 == SZ_BU) || (cpu_funct3 == SZ_HU);
  assign misaligned = ((cpu_funct3[1:0] == 2'b01) && cpu_addr[0]) ||
                      ((cpu_funct3[1:0] == 2'b10) && (cpu_addr[1:0] != 2'b00));
  assign req_be     = store_be(cpu_funct3, cpu_addr[1:0]);
  assign req_lanes  = store_lanes(cpu_funct3, cpu_wdata);

  mem_bus_ram #(
    .WORDS (RAM_WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (req_be),
    .addr  (cpu_addr[RAM_AW+1:2]),
    .wdata (req_lanes),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    io_req_d   = io_req_q;
    io_we_d    = io_we_q;
    io_addr_d  = io_addr_q;
    io_wdata_d = io_wdata_q;
    io_be_d    = io_be_q;
    f3_d       = f3_q;
    off_d      = off_q;
    ram_we     = 1'b0;
`ifdef MEM_BUS_IO_TIMEOUT_EN
    tmr_d      = tmr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          f3_d    = cpu_funct3;
          off_d   = cpu_addr[1:0];
          err_d   = 1'b0;
          rdata_d = '0;
          if (!f3_legal || misaligned) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            case (region)
              REG_RAM: begin
                if (cpu_we) begin
                  ram_we  = 1'b1;
                  state_d = ST_RESP;
                end else begin
                  state_d = ST_RAM_RD;
                end
              end
              REG_IO: begin
                io_req_d   = 1'b1;
                io_we_d    = cpu_we;
                io_addr_d  = {cpu_addr[31:2], 2'b00};
                io_wdata_d = req_lanes;
                io_be_d    = req_be;
`ifdef MEM_BUS_IO_TIMEOUT_EN
                tmr_d      = '0;
`endif
                state_d    = ST_IO_WAIT;
              end
              default: begin
                err_d   = 1'b1;
                state_d = ST_RESP;
              end
            endcase
          end
        end
      end

      ST_RAM_RD: begin
        rdata_d = fmt_load(ram_rdata, off_q, f3_q);
        state_d = ST_RESP;
      end

      ST_IO_WAIT: begin
        // Ack is checked first so it wins over a same-cycle timeout expiry.
        if (io_ack) begin
          io_req_d = 1'b0;
          rdata_d  = io_we_q ? 32'h0 : fmt_load(io_rdata, off_q, f3_q);
          state_d  = ST_RESP;
        end
`ifdef MEM_BUS_IO_TIMEOUT_EN
        else if (tmr_q == TMO_LAST) begin
          io_req_d = 1'b0;
          err_d    = 1'b1;
          rdata_d  = '0;
          state_d  = ST_RESP;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
`endif
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      io_req_q   <= 1'b0;
      io_we_q    <= 1'b0;
      io_addr_q  <= '0;
      io_wdata_q <= '0;
      io_be_q    <= '0;
      f3_q       <= '0;
      off_q      <= '0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      io_req_q   <= io_req_d;
      io_we_q    <= io_we_d;
      io_addr_q  <= io_addr_d;
      io_wdata_q <= io_wdata_d;
      io_be_q    <= io_be_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
    end
  end

`ifdef MEM_BUS_IO_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) tmr_q <= '0;
    else     tmr_q <= tmr_d;
  end
`endif

  assign cpu_done  = (state_q == ST_RESP);
  assign cpu_err   = cpu_done & err_q;
  assign cpu_rdata = cpu_done ? rdata_q : 32'h0;
  assign io_req    = io_req_q;
  assign io_we     = io_we_q;
  assign io_addr   = io_addr_q;
  assign io_wdata  = io_wdata_q;
  assign io_be     = io_be_q;

endmodule
